// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared stage constants, NOP payloads and the stage update selector.
package pipe_stage_reg_pkg;

    localparam int STALL_W_DEF = 6;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    localparam logic [7:0]  EX_NOP_OP    = 8'h00;
    localparam logic [2:0]  EX_RES_NOP   = 3'b000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
    localparam logic [31:0] ZERO_WORD    = 32'h0;

    // Per-stage bubble payloads; each wrapper concatenates the fields it carries.
    localparam logic [31:0] IF_ID_NOP  = ZERO_WORD;
    localparam logic [47:0] ID_EX_NOP  = {EX_NOP_OP, EX_RES_NOP, NOP_REG_ADDR, ZERO_WORD};
    localparam logic [37:0] EX_MEM_NOP = {NOP_REG_ADDR, 1'b0, ZERO_WORD};
    localparam logic [37:0] MEM_WB_NOP = {NOP_REG_ADDR, 1'b0, ZERO_WORD};

    typedef enum logic [2:0] {
        SEL_FLUSH,
        SEL_BUBBLE,
        SEL_HOLD,
        SEL_KILL,
        SEL_PASS
    } sel_e;

    function automatic sel_e stage_sel(input logic flush, input logic stall_here,
                                       input logic stall_down, input logic kill);
        return flush ? SEL_FLUSH :
               (stall_here && !stall_down) ? SEL_BUBBLE :
               stall_here ? SEL_HOLD :
               kill ? SEL_KILL : SEL_PASS;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid + payload bundle between adjacent pipeline stages.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data);
    modport slave  (input  valid, input  data);
endinterface

// File: rtl/pipe_stage_reg_squash_ctrl.sv
// squash_ctrl: post-flush squash counter, pending flag and saturating discard statistics.
module squash_ctrl #(
    parameter int SQUASH_DEPTH = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             advance,
    input  logic             in_valid,
    input  logic             clr_stats,
    output logic             kill,
    output logic             squash_pending,
    output logic [CNT_W-1:0] squash_total
);
    localparam int SW = $clog2(SQUASH_DEPTH + 1);

    logic [SW-1:0]    cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic             busy, inc;

    always_comb begin
        busy   = cnt_q != '0;
        inc    = advance && in_valid && (flush || busy);
        // The flush-cycle advance already consumes one squash slot.
        cnt_d  = flush ? (advance ? SW'(SQUASH_DEPTH - 1) : SW'(SQUASH_DEPTH)) :
                 (advance && busy) ? cnt_q - 1'b1 : cnt_q;
        pend_d = cnt_d != '0;
        tot_d  = clr_stats ? CNT_W'(inc) :
                 (inc && !(&tot_q)) ? tot_q + 1'b1 : tot_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            tot_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            tot_q  <= tot_d;
        end
    end

    assign kill           = flush || busy;
    assign squash_pending = pend_q;
    assign squash_total   = tot_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage register with stall/bubble handling and flush squash.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                STALL_W      = STALL_W_DEF,
    parameter int                STAGE_IDX    = STAGE_EX,
    parameter logic [DATA_W-1:0] NOP_VALUE    = '0,
    parameter int                SQUASH_DEPTH = 1,
    parameter int                CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    pipe_stage_reg_if.slave    up,
    pipe_stage_reg_if.master   dn,
    output logic               squash_pending,
    output logic [CNT_W-1:0]   squash_total,
    input  logic               clr_stats
);
    logic              stall_here, stall_down, kill;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    sel_e              sel;
    logic              unused_stall;

    assign stall_here   = stall[STAGE_IDX];
    assign stall_down   = stall[STAGE_IDX+1];
    assign unused_stall = ^stall;

    squash_ctrl #(
        .SQUASH_DEPTH (SQUASH_DEPTH),
        .CNT_W        (CNT_W)
    ) u_squash (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .advance        (!stall_here),
        .in_valid       (up.valid),
        .clr_stats      (clr_stats),
        .kill           (kill),
        .squash_pending (squash_pending),
        .squash_total   (squash_total)
    );

    always_comb begin
        sel     = stage_sel(flush, stall_here, stall_down, kill);
        valid_d = (sel == SEL_HOLD) ? valid_q : (sel == SEL_PASS) && up.valid;
        data_d  = (sel == SEL_HOLD) ? data_q :
                  (sel == SEL_PASS && up.valid) ? up.data : NOP_VALUE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn.valid = valid_q;
    assign dn.data  = data_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench over three configurations (depth 1, depth 3, 2-bit stats).
module tb_pipe_stage_reg;
    localparam logic [31:0] N = 32'h0000_0013;
    localparam logic [5:0]  RUN = 6'b000000, BUB = 6'b000100, HLD = 6'b001100;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        p;
        logic [15:0] t;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, clr = 1'b0;
    logic [5:0]  stall = '0;
    logic        p1, p3, ps;
    logic [15:0] t1, t3;
    logic [1:0]  ts;
    int          sel = 1;
    int          checks = 0, failures = 0;
    exp_t        sb[$];
    logic        o_v, o_p;
    logic [31:0] o_d;
    logic [15:0] o_t;

    pipe_stage_reg_if #(.DATA_W(32)) up_if ();
    pipe_stage_reg_if #(.DATA_W(32)) dn1 ();
    pipe_stage_reg_if #(.DATA_W(32)) dn3 ();
    pipe_stage_reg_if #(.DATA_W(32)) dns ();

    pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE_IDX(2), .NOP_VALUE(N), .SQUASH_DEPTH(1), .CNT_W(16)) d1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .up(up_if), .dn(dn1),
        .squash_pending(p1), .squash_total(t1), .clr_stats(clr));
    pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE_IDX(2), .NOP_VALUE(N), .SQUASH_DEPTH(3), .CNT_W(16)) d3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .up(up_if), .dn(dn3),
        .squash_pending(p3), .squash_total(t3), .clr_stats(clr));
    pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE_IDX(2), .NOP_VALUE(N), .SQUASH_DEPTH(1), .CNT_W(2)) ds (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .up(up_if), .dn(dns),
        .squash_pending(ps), .squash_total(ts), .clr_stats(clr));

    always #5 clk = ~clk;

    always_comb begin
        o_v = sel == 1 ? dn1.valid : sel == 3 ? dn3.valid : dns.valid;
        o_d = sel == 1 ? dn1.data  : sel == 3 ? dn3.data  : dns.data;
        o_p = sel == 1 ? p1 : sel == 3 ? p3 : ps;
        o_t = sel == 1 ? t1 : sel == 3 ? t3 : {14'd0, ts};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [5:0] st, input logic fl, input logic iv, input logic [31:0] id,
                        input logic cl, input logic ev, input logic [31:0] ed, input logic ep,
                        input logic [15:0] et);
        exp_t e;
        stall = st; flush = fl; up_if.valid = iv; up_if.data = id; clr = cl;
        sb.push_back('{ev, ed, ep, et});
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("out_valid", 64'(o_v), 64'(e.v));
        chk("out_data", 64'(o_d), 64'(e.d));
        chk("squash_pending", 64'(o_p), 64'(e.p));
        chk("squash_total", 64'(o_t), 64'(e.t));
    endtask

    task automatic idle_inputs();
        stall = RUN; flush = 1'b0; up_if.valid = 1'b0; up_if.data = '0; clr = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_valid"}, 64'(o_v), 64'(1'b0));
        chk({tag, "_data"}, 64'(o_d), 64'(N));
        chk({tag, "_pending"}, 64'(o_p), 64'(1'b0));
        chk({tag, "_total"}, 64'(o_t), 64'(16'd0));
        idle_inputs();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        #12;
        chk("rst_valid", 64'(o_v), 64'(1'b0));
        chk("rst_data", 64'(o_d), 64'(N));
        chk("rst_total", 64'(o_t), 64'(16'd0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // depth 1: reset mid-operation with a non-zero total
        sel = 1;
        step(RUN, 1, 1, 32'hA5A5A5A5, 0, 0, N, 0, 1);
        repeat (3) step(RUN, 0, 1, 32'hA5A5A5A5, 0, 1, 32'hA5A5A5A5, 0, 1);
        async_reset_check("amid");
        // bubble, hold, resume
        step(RUN, 0, 1, 32'h10, 0, 1, 32'h10, 0, 0);
        step(BUB, 0, 1, 32'h11, 0, 0, N, 0, 0);
        step(RUN, 0, 1, 32'h22, 0, 1, 32'h22, 0, 0);
        repeat (4) step(HLD, 0, 1, 32'h99, 0, 1, 32'h22, 0, 0);
        step(RUN, 0, 1, 32'h33, 0, 1, 32'h33, 0, 0);
        // single-instruction squash
        step(RUN, 1, 1, 32'h44, 0, 0, N, 0, 1);
        step(RUN, 0, 1, 32'h55, 0, 1, 32'h55, 0, 1);
        step(HLD, 1, 1, 32'h60, 0, 0, N, 1, 1);
        step(RUN, 0, 1, 32'h66, 0, 0, N, 0, 2);
        step(RUN, 0, 1, 32'h77, 0, 1, 32'h77, 0, 2);
        step(RUN, 0, 0, 32'hFF, 0, 0, N, 0, 2);

        // depth 3
        sel = 3;
        rst = 1'b0; idle_inputs(); #3;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        step(HLD, 1, 0, 32'h0, 0, 0, N, 1, 0);
        step(RUN, 0, 1, 32'h1, 0, 0, N, 1, 1);
        step(HLD, 0, 1, 32'h2, 0, 0, N, 1, 1);
        step(RUN, 0, 1, 32'h2, 0, 0, N, 1, 2);
        step(RUN, 0, 1, 32'h3, 0, 0, N, 0, 3);
        step(RUN, 0, 1, 32'h4, 0, 1, 32'h4, 0, 3);
        step(RUN, 1, 1, 32'h5, 0, 0, N, 1, 4);
        step(RUN, 0, 1, 32'h6, 0, 0, N, 1, 5);
        step(RUN, 1, 1, 32'h7, 0, 0, N, 1, 6);
        step(RUN, 0, 1, 32'h8, 0, 0, N, 1, 7);
        step(RUN, 0, 1, 32'h9, 0, 0, N, 0, 8);
        step(RUN, 0, 1, 32'hA, 0, 1, 32'hA, 0, 8);
        // invalid advances drain the counter without counting
        step(RUN, 1, 0, 32'h0, 0, 0, N, 1, 8);
        step(RUN, 0, 0, 32'hFF, 0, 0, N, 1, 8);
        step(RUN, 0, 0, 32'hFF, 0, 0, N, 0, 8);
        step(RUN, 0, 1, 32'hB, 0, 1, 32'hB, 0, 8);
        // reset mid-squash discards the pending squash
        step(RUN, 1, 1, 32'hC, 0, 0, N, 1, 9);
        async_reset_check("msq");
        step(RUN, 0, 1, 32'hD, 0, 1, 32'hD, 0, 0);
        // bubble freezes the counter
        step(RUN, 1, 0, 32'h0, 0, 0, N, 1, 0);
        step(BUB, 0, 1, 32'hE, 0, 0, N, 1, 0);
        step(RUN, 0, 1, 32'hE, 0, 0, N, 1, 1);
        step(RUN, 0, 1, 32'hE, 0, 0, N, 0, 2);
        step(RUN, 0, 1, 32'hF, 0, 1, 32'hF, 0, 2);

        // 2-bit statistics saturation and clear
        sel = 2;
        rst = 1'b0; idle_inputs(); #3;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++)
            step(RUN, 1, 1, 32'(k), 0, 0, N, 0, 16'(k > 3 ? 3 : k));
        step(RUN, 1, 1, 32'h6, 1, 0, N, 0, 1);
        step(RUN, 0, 0, 32'h0, 1, 0, N, 0, 0);
        step(RUN, 0, 1, 32'h7, 0, 1, 32'h7, 0, 0);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of width DATA_W with a valid bit.
- Honours the shared stall vector and inserts a bubble when this stage stalls but the next stage does not.
- Handles control-flow flush with a programmable squash depth, and counts discarded valid instructions for performance analysis.

Parameters:
DATA_W, 32, payload width in bits
STALL_W, 6, width of the shared stall vector
STAGE_IDX, 2, index of this stage's bit in stall; stall[STAGE_IDX+1] is the downstream bit; must satisfy STAGE_IDX+1 < STALL_W
NOP_VALUE, {DATA_W{1'b0}}, payload driven during bubble, flush and reset
SQUASH_DEPTH, 1, number of upstream advances (including the flush-cycle advance) discarded after a flush; range 1..15
CNT_W, 16, width of the saturating squash statistics counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low
stall  in  STALL_W  shared pipeline stall vector
flush  in  1  branch/jump taken, kill in-flight younger work
in_valid  in  1  upstream payload valid
in_data  in  DATA_W  upstream payload
out_valid  out  1  registered payload valid
out_data  out  DATA_W  registered payload
squash_pending  out  1  squash counter non-zero
squash_total  out  CNT_W  saturating count of valid inputs discarded by squash
clr_stats  in  1  synchronous clear of squash_total

Behaviour:
Per-cycle qualifiers:
- stall_here = stall[STAGE_IDX]
- stall_down = stall[STAGE_IDX+1]
- advance = !stall_here
- bubble = stall_here && !stall_down
- hold = stall_here && stall_down

Reset (rst=0, asynchronous, dominates everything):
- out_valid=0, out_data=NOP_VALUE
- squash counter=0, squash_total=0
- Reset asserted mid-squash discards the pending squash.

Register update on a clock edge, priority order:
1. flush=1:
   - out_valid=0, out_data=NOP_VALUE, regardless of stall.
   - Counter loads SQUASH_DEPTH-1 if advance, else SQUASH_DEPTH. The flush-cycle advance counts as the first squashed advance.
   - If advance && in_valid, squash_total increments.
   - A flush while the counter is non-zero reloads the counter; squashes do not accumulate.
2. bubble:
   - out_valid=0, out_data=NOP_VALUE.
   - Counter unchanged.
3. hold:
   - out_valid and out_data retained.
   - Counter unchanged.
4. advance with counter>0:
   - out_valid=0, out_data=NOP_VALUE.
   - Counter decrements on every advance, valid or not.
   - squash_total increments if in_valid.
5. advance with counter==0:
   - out_valid=in_valid.
   - out_data=in_data if in_valid, else NOP_VALUE.

Other rules:
- Latency is 1 cycle from input to output when advancing.
- squash_pending = (counter != 0), registered.
- squash_total:
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_stats clears it on the next edge.
  - If clr_stats and an increment coincide, the result is 1.
- Counter width is $clog2(SQUASH_DEPTH+1); arithmetic is unsigned and never underflows.
- SQUASH_DEPTH=1 reproduces the current single-instruction squash exactly:
  - Flush with advance: the incoming instruction is squashed and nothing is left pending.
  - Flush while stalled: the next advance is squashed.

Decomposition:
- Defines.vh holds:
  - the STALL_W default
  - stage index constants STAGE_IF..STAGE_WB
  - per-stage NOP payload constants, built from the existing EX_NOP_OP / EX_RES_NOP / NOPRegAddr / ZeroWord fields and concatenated in the stage wrapper
- One sub-module, squash_ctrl:
  - contains the counter, squash_pending and the saturating squash_total logic
  - inputs: flush, advance, in_valid, clr_stats
  - output: kill (counter>0 || flush)
- pipe_stage_reg contains only the payload/valid register and the priority mux.

Test Plan:
1. Reset mid-operation: drive in_data=0xA5A5A5A5 with in_valid=1, advance 3 cycles, then pull rst low asynchronously between edges -> out_valid=0 and out_data=NOP immediately; squash_total=0.
2. Stall pair:
   - stall=6'b000100 (bubble) with in_data=0x11 -> out_valid=0, out_data=NOP.
   - stall=6'b001100 (hold) after loading 0x22 -> 0x22 held for 4 cycles.
   - stall=0 -> next input 0x33 appears after 1 cycle.
3. Flush, SQUASH_DEPTH=1:
   - flush with advance and in_data=0x44 valid -> output NOP, squash_pending=0, squash_total=1; following 0x55 passes.
   - flush during hold -> the next advance of 0x66 is squashed, then 0x77 passes.
4. SQUASH_DEPTH=3: flush, then stream 0x1,0x2,0x3,0x4 with one hold cycle inserted -> 0x1..0x3 squashed, 0x4 output, squash_total=3; a second flush on the 2nd squash reloads the counter -> 3 further advances squashed.
5. Saturation: CNT_W=2, produce 5 squashed valid inputs -> squash_total sticks at 3; clr_stats coinciding with a squash -> 1.
6. Invalid traffic: advance with in_valid=0 and in_data=0xFF -> out_valid=0, out_data=NOP; during a squash, invalid advances decrement the counter but do not increment squash_total.
